// File: rtl/gray_pkg.sv
// Shared constants, types and luma helper for the grey/horizontal-filter pixel stage.
package gray_pkg;

  localparam int unsigned PIX_W      = 8;
  localparam int unsigned COEF_R     = 77;
  localparam int unsigned COEF_G     = 150;
  localparam int unsigned COEF_B     = 29;
  localparam int unsigned LUMA_SHIFT = 8;
  localparam int unsigned LUMA_SUM_W = 16;
  localparam int unsigned FILT_SUM_W = 10;
  localparam int unsigned FILT_SHIFT = 2;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb_t;

  // Weighted sum fits 16 bits exactly (coefficients add up to 256).
  function automatic logic [PIX_W-1:0] luma(input rgb_t p);
    logic [LUMA_SUM_W-1:0] s;
    s = LUMA_SUM_W'(COEF_R) * LUMA_SUM_W'(p.r)
      + LUMA_SUM_W'(COEF_G) * LUMA_SUM_W'(p.g)
      + LUMA_SUM_W'(COEF_B) * LUMA_SUM_W'(p.b);
    return PIX_W'(s >> LUMA_SHIFT);
  endfunction

endpackage

// File: rtl/rgb2gray.sv
// One-stage registered RGB-to-luma converter with a pass-along valid.
module rgb2gray
  import gray_pkg::*;
(
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             in_valid,
  input  rgb_t             pix,
  output logic             y_valid,
  output logic [PIX_W-1:0] y
);

  logic             y_valid_q, y_valid_d;
  logic [PIX_W-1:0] y_q, y_d;

  always_comb begin
    y_valid_d = in_valid;
    y_d       = y_q;
    if (in_valid) y_d = luma(pix);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      y_valid_q <= 1'b0;
      y_q       <= '0;
    end else begin
      y_valid_q <= y_valid_d;
      y_q       <= y_d;
    end
  end

  assign y_valid = y_valid_q;
  assign y       = y_q;

endmodule

// File: rtl/gray_hfilter_stream.sv
// Raster RGB -> luma -> [1 2 1]/4 horizontal smoothing stage driving the BMP writer.
// Optional binarisation of the filtered value is enabled with `GRAY_THRESH_EN.
module gray_hfilter_stream
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH  = 768,
  parameter int unsigned HEIGHT = 512
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_R,
  input  logic [PIX_W-1:0] in_G,
  input  logic [PIX_W-1:0] in_B,
  input  logic [PIX_W-1:0] thresh,
  output logic             hsync,
  output logic [PIX_W-1:0] DATA_WRITE_R,
  output logic [PIX_W-1:0] DATA_WRITE_G,
  output logic [PIX_W-1:0] DATA_WRITE_B,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               flush_q, flush_d;
  logic               flush_last_q, flush_last_d;
  logic [PIX_W-1:0]   w0_q, w0_d;
  logic [PIX_W-1:0]   w1_q, w1_d;
  logic               have_q, have_d;
  logic               hsync_q, hsync_d;
  logic [PIX_W-1:0]   data_q, data_d;
  logic               frame_done_q, frame_done_d;

  logic               hs_c;
  rgb_t               pix_c;
  logic               y_valid;
  logic [PIX_W-1:0]   y;
  logic [PIX_W-1:0]   tap_c;
  logic [FILT_SUM_W-1:0] fsum_c;
  logic [PIX_W-1:0]   filt_c;
  logic [PIX_W-1:0]   res_c;

`ifdef GRAY_THRESH_EN
  logic [PIX_W-1:0]   thresh_q, thresh_d;
`else
  logic               unused_thresh;
  assign unused_thresh = ^thresh;
`endif

  assign hs_c  = in_valid & in_ready_q;
  assign pix_c = '{r: in_R, g: in_G, b: in_B};

  rgb2gray u_rgb2gray (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .in_valid (hs_c),
    .pix      (pix_c),
    .y_valid  (y_valid),
    .y        (y)
  );

  // Frame sequencing: column/row tracking, flush injection, drain to frame_done.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    flush_d      = 1'b0;
    flush_last_d = 1'b0;
`ifdef GRAY_THRESH_EN
    thresh_d     = thresh_q;
`endif
    case (state_q)
      IDLE: begin
        if (hs_c) begin
          state_d = RUN;
          col_d   = COL_W'(1);
`ifdef GRAY_THRESH_EN
          thresh_d = thresh;
`endif
        end
      end
      RUN: begin
        if (hs_c) begin
          if (col_q == COL_W'(WIDTH - 1)) begin
            col_d   = '0;
            state_d = FLUSH;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      FLUSH: begin
        flush_d = 1'b1;
        if (row_q == ROW_W'(HEIGHT - 1)) begin
          flush_last_d = 1'b1;
          row_d        = '0;
          state_d      = DRAIN;
        end else begin
          row_d   = row_q + ROW_W'(1);
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (frame_done_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE) || (state_d == RUN);
    busy_d     = (state_d != IDLE);
  end

  // Right-edge flush replicates the newest tap; otherwise the incoming luma is the right tap.
  assign tap_c  = y_valid ? y : w1_q;
  assign fsum_c = FILT_SUM_W'(w0_q) + FILT_SUM_W'({w1_q, 1'b0}) + FILT_SUM_W'(tap_c);
  assign filt_c = PIX_W'(fsum_c >> FILT_SHIFT);

`ifdef GRAY_THRESH_EN
  assign res_c = (filt_c >= thresh_q) ? 8'hFF : 8'h00;
`else
  assign res_c = filt_c;
`endif

  // 3-tap window: first pixel of a line seeds both taps (left-edge replicate).
  always_comb begin
    w0_d         = w0_q;
    w1_d         = w1_q;
    have_d       = have_q;
    hsync_d      = 1'b0;
    data_d       = data_q;
    frame_done_d = 1'b0;
    if (y_valid) begin
      if (!have_q) begin
        w0_d   = y;
        w1_d   = y;
        have_d = 1'b1;
      end else begin
        hsync_d = 1'b1;
        data_d  = res_c;
        w0_d    = w1_q;
        w1_d    = y;
      end
    end else if (flush_q) begin
      hsync_d      = 1'b1;
      data_d       = res_c;
      have_d       = 1'b0;
      frame_done_d = flush_last_q;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      flush_q      <= 1'b0;
      flush_last_q <= 1'b0;
      w0_q         <= '0;
      w1_q         <= '0;
      have_q       <= 1'b0;
      hsync_q      <= 1'b0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
`ifdef GRAY_THRESH_EN
      thresh_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      flush_q      <= flush_d;
      flush_last_q <= flush_last_d;
      w0_q         <= w0_d;
      w1_q         <= w1_d;
      have_q       <= have_d;
      hsync_q      <= hsync_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
`ifdef GRAY_THRESH_EN
      thresh_q     <= thresh_d;
`endif
    end
  end

  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign hsync        = hsync_q;
  assign DATA_WRITE_R = data_q;
  assign DATA_WRITE_G = data_q;
  assign DATA_WRITE_B = data_q;
  assign frame_done   = frame_done_q;

endmodule
